reg_file_sb: RTL and testbench



---
 rtl/rf_pkg.sv | 35 +++
 rtl/rf_scoreboard.sv | 55 +++++
 rtl/reg_file_sb.sv | 81 ++++++++
 tb/tb_reg_file_sb.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types, constants and lane-merge helper
// for the scoreboarded register file.
package rf_pkg;

  localparam logic [1:0] HMASK_NONE = 2'b00;
  localparam logic [1:0] HMASK_LO   = 2'b01;
  localparam logic [1:0] HMASK_HI   = 2'b10;
  localparam logic [1:0] HMASK_ALL  = 2'b11;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 8;

  // Widest register the merge helper supports.
  localparam int MAX_W = 64;

  // Per-lane select; half is the lane width in bits.
  function automatic logic [MAX_W-1:0] merge_half(
    input logic [MAX_W-1:0] old_v,
    input logic [MAX_W-1:0] new_v,
    input logic [1:0]       mask,
    input int               half
  );
    logic [MAX_W-1:0] r;
    r = old_v;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < half) begin
        if (mask[0]) r[i] = new_v[i];
      end else if (i < 2 * half) begin
        if (mask[1]) r[i] = new_v[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register,
// issue sets, completion clears, set wins on collision.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  output logic              busy_any
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;

  // Next busy vector: clear on completion, then set on issue.
  always_comb begin
    busy_nxt = busy;
    if (wr_en)    busy_nxt[wr_addr]    = 1'b0;
    if (issue_en) busy_nxt[issue_addr] = 1'b1;
  end

  // Busy vector register.
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  // Busy read ports; an in-flight clear shows its post-edge result.
  always_comb begin
    rd_busy1 = 1'b0;
    rd_busy2 = 1'b0;
    busy_any = 1'b0;
    if (!rst) begin
      rd_busy1 = busy[rd_addr1];
      rd_busy2 = busy[rd_addr2];
      if (BYPASS != 0 && wr_en && wr_addr == rd_addr1)
        rd_busy1 = issue_en && issue_addr == rd_addr1;
      if (BYPASS != 0 && wr_en && wr_addr == rd_addr2)
        rd_busy2 = issue_en && issue_addr == rd_addr2;
      busy_any = |busy;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with half-word write mask, write-to-read
// bypass and a per-register pending scoreboard.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        wr_hmask,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              busy_any
);

  localparam int HALF = DATA_W / 2;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] wr_merged;

  // Lane merge of the incoming write onto the stored value.
  always_comb begin
    wr_merged = DATA_W'(merge_half(MAX_W'(regs[wr_addr]),
                                   MAX_W'(wr_data),
                                   wr_hmask, HALF));
  end

  // Storage update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_merged;
    end
  end

  // Data read ports with optional same-cycle forwarding.
  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    if (!rst) begin
      rd_data1 = regs[rd_addr1];
      rd_data2 = regs[rd_addr2];
      if (BYPASS != 0 && wr_en && wr_addr == rd_addr1)
        rd_data1 = wr_merged;
      if (BYPASS != 0 && wr_en && wr_addr == rd_addr2)
        rd_data2 = wr_merged;
    end
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .BYPASS   (BYPASS)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .rd_addr1   (rd_addr1),
    .rd_addr2   (rd_addr2),
    .rd_busy1   (rd_busy1),
    .rd_busy2   (rd_busy2),
    .busy_any   (busy_any)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: bypass, no-bypass and 16x16
// instances against an abstract model plus literal checks.
module tb_reg_file_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  rd_addr1, rd_addr2, wr_addr, issue_addr;
  logic        wr_en, issue_en;
  logic [31:0] wr_data;
  logic [1:0]  wr_hmask;

  logic [31:0] a_rd_data1, a_rd_data2, n_rd_data1, n_rd_data2;
  logic        a_rd_busy1, a_rd_busy2, a_busy_any;
  logic        n_rd_busy1, n_rd_busy2, n_busy_any;

  logic [3:0]  b_rd_addr1, b_rd_addr2, b_wr_addr, b_issue_addr;
  logic        b_wr_en, b_issue_en;
  logic [15:0] b_wr_data;
  logic [1:0]  b_wr_hmask;
  logic [15:0] b_rd_data1, b_rd_data2;
  logic        b_rd_busy1, b_rd_busy2, b_busy_any;

  int errors = 0;
  int checks = 0;

  reg_file_sb #(.BYPASS(1)) u_a (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(a_rd_data1), .rd_data2(a_rd_data2),
    .rd_busy1(a_rd_busy1), .rd_busy2(a_rd_busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_hmask(wr_hmask), .issue_en(issue_en),
    .issue_addr(issue_addr), .busy_any(a_busy_any)
  );

  reg_file_sb #(.BYPASS(0)) u_n (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(n_rd_data1), .rd_data2(n_rd_data2),
    .rd_busy1(n_rd_busy1), .rd_busy2(n_rd_busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_hmask(wr_hmask), .issue_en(issue_en),
    .issue_addr(issue_addr), .busy_any(n_busy_any)
  );

  reg_file_sb #(.DATA_W(16), .NUM_REGS(16)) u_b (
    .clk(clk), .rst(rst),
    .rd_addr1(b_rd_addr1), .rd_addr2(b_rd_addr2),
    .rd_data1(b_rd_data1), .rd_data2(b_rd_data2),
    .rd_busy1(b_rd_busy1), .rd_busy2(b_rd_busy2),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .wr_hmask(b_wr_hmask),
    .issue_en(b_issue_en), .issue_addr(b_issue_addr),
    .busy_any(b_busy_any)
  );

  // ---------------- model ----------------
  logic [31:0] mreg [8];
  logic [7:0]  mbusy;
  logic [15:0] breg [16];

  function automatic logic [31:0] lane32(
    input logic [31:0] o, input logic [31:0] n,
    input logic [1:0] m);
    return {m[1] ? n[31:16] : o[31:16],
            m[0] ? n[15:0]  : o[15:0]};
  endfunction

  function automatic logic [15:0] lane16(
    input logic [15:0] o, input logic [15:0] n,
    input logic [1:0] m);
    return {m[1] ? n[15:8] : o[15:8],
            m[0] ? n[7:0]  : o[7:0]};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) mreg[i] <= '0;
      for (int i = 0; i < 16; i++) breg[i] <= '0;
      mbusy <= '0;
    end else begin
      if (wr_en) begin
        mreg[wr_addr]  <= lane32(mreg[wr_addr], wr_data, wr_hmask);
        mbusy[wr_addr] <= 1'b0;
      end
      if (issue_en) mbusy[issue_addr] <= 1'b1;
      if (b_wr_en)
        breg[b_wr_addr] <= lane16(breg[b_wr_addr], b_wr_data, b_wr_hmask);
    end
  end

  function automatic logic [31:0] exp_data(input logic [2:0] a,
                                           input bit byp);
    if (rst) return 32'h0;
    if (byp && wr_en && wr_addr == a)
      return lane32(mreg[a], wr_data, wr_hmask);
    return mreg[a];
  endfunction

  function automatic logic exp_busy(input logic [2:0] a,
                                    input bit byp);
    if (rst) return 1'b0;
    if (byp && wr_en && wr_addr == a)
      return issue_en && issue_addr == a;
    return mbusy[a];
  endfunction

  function automatic logic [15:0] exp_b(input logic [3:0] a);
    if (rst) return 16'h0;
    if (b_wr_en && b_wr_addr == a)
      return lane16(breg[a], b_wr_data, b_wr_hmask);
    return breg[a];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("a_data1", a_rd_data1, exp_data(rd_addr1, 1'b1));
    chk("a_data2", a_rd_data2, exp_data(rd_addr2, 1'b1));
    chk("a_busy1", 32'(a_rd_busy1), 32'(exp_busy(rd_addr1, 1'b1)));
    chk("a_busy2", 32'(a_rd_busy2), 32'(exp_busy(rd_addr2, 1'b1)));
    chk("a_any", 32'(a_busy_any), 32'(!rst && |mbusy));
    chk("n_data1", n_rd_data1, exp_data(rd_addr1, 1'b0));
    chk("n_data2", n_rd_data2, exp_data(rd_addr2, 1'b0));
    chk("n_busy1", 32'(n_rd_busy1), 32'(exp_busy(rd_addr1, 1'b0)));
    chk("n_busy2", 32'(n_rd_busy2), 32'(exp_busy(rd_addr2, 1'b0)));
    chk("n_any", 32'(n_busy_any), 32'(!rst && |mbusy));
    chk("b_data1", 32'(b_rd_data1), 32'(exp_b(b_rd_addr1)));
    chk("b_data2", 32'(b_rd_data2), 32'(exp_b(b_rd_addr2)));
    chk("b_any", 32'(b_busy_any), 32'h0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d,
                    input logic [1:0] m);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_hmask = m;
  endtask

  task automatic bwr(input logic [3:0] a, input logic [15:0] d,
                     input logic [1:0] m);
    b_wr_en = 1'b1; b_wr_addr = a; b_wr_data = d; b_wr_hmask = m;
  endtask

  initial begin
    rst = 1'b1;
    rd_addr1 = '0; rd_addr2 = '0; wr_addr = '0; issue_addr = '0;
    wr_en = 1'b0; issue_en = 1'b0; wr_data = '0; wr_hmask = '0;
    b_rd_addr1 = '0; b_rd_addr2 = '0; b_wr_addr = '0;
    b_issue_addr = '0; b_wr_en = 1'b0; b_issue_en = 1'b0;
    b_wr_data = '0; b_wr_hmask = '0;
    tick();
    mid();
    chk("rst_data", a_rd_data1, 32'h0);
    chk("rst_any", 32'(a_busy_any), 32'h0);
    tick();
    rst = 1'b0;

    // Reset mid-activity
    wr(3'd3, 32'h1234_5678, 2'b11);
    tick();
    wr_en = 1'b0;
    issue_en = 1'b1; issue_addr = 3'd5;
    tick();
    issue_en = 1'b0;
    rd_addr1 = 3'd3; rd_addr2 = 3'd5;
    mid();
    chk("t1_r3", a_rd_data1, 32'h1234_5678);
    chk("t1_b5", 32'(a_rd_busy2), 32'h1);
    tick();
    rst = 1'b1;
    wr(3'd3, 32'hFFFF_FFFF, 2'b11);
    issue_en = 1'b1; issue_addr = 3'd2;
    mid();
    chk("t1_inrst", a_rd_data1, 32'h0);
    tick();
    rst = 1'b0; wr_en = 1'b0; issue_en = 1'b0;
    mid();
    chk("t1_r3_0", a_rd_data1, 32'h0);
    chk("t1_b5_0", 32'(a_rd_busy2), 32'h0);
    chk("t1_any", 32'(a_busy_any), 32'h0);
    tick();

    // MOV then MOVT, then low-half write
    wr(3'd0, 32'h0000_FFFF, 2'b11);
    tick();
    wr(3'd0, 32'hEEEE_0000, 2'b10);
    tick();
    wr_en = 1'b0;
    rd_addr1 = 3'd0;
    mid();
    chk("t2_movt", a_rd_data1, 32'hEEEE_FFFF);
    tick();
    wr(3'd0, 32'h0000_1111, 2'b01);
    tick();
    wr_en = 1'b0;
    mid();
    chk("t2_lo", a_rd_data1, 32'hEEEE_1111);
    tick();

    // Bypass versus stored-only read
    wr(3'd2, 32'hAAAA_AAAA, 2'b11);
    tick();
    wr(3'd2, 32'h5555_5555, 2'b11);
    rd_addr1 = 3'd2; rd_addr2 = 3'd2;
    mid();
    chk("t3_a1", a_rd_data1, 32'h5555_5555);
    chk("t3_a2", a_rd_data2, 32'h5555_5555);
    chk("t3_n1", n_rd_data1, 32'hAAAA_AAAA);
    chk("t3_n2", n_rd_data2, 32'hAAAA_AAAA);
    tick();
    wr_en = 1'b0;

    // Scoreboard lifecycle
    issue_en = 1'b1; issue_addr = 3'd1;
    tick();
    issue_en = 1'b0;
    rd_addr1 = 3'd1;
    mid();
    chk("t4_busy", 32'(a_rd_busy1), 32'h1);
    chk("t4_any", 32'(a_busy_any), 32'h1);
    tick();
    wr(3'd1, 32'hDEAD_BEEF, 2'b00);
    mid();
    chk("t4_byp0", 32'(a_rd_busy1), 32'h0);
    chk("t4_nbyp", 32'(n_rd_busy1), 32'h1);
    chk("t4_data", a_rd_data1, 32'h0);
    tick();
    wr_en = 1'b0;
    mid();
    chk("t4_any0", 32'(a_busy_any), 32'h0);
    chk("t4_keep", a_rd_data1, 32'h0);
    tick();

    // Simultaneous issue and completion
    issue_en = 1'b1; issue_addr = 3'd7;
    tick();
    issue_addr = 3'd4;
    wr(3'd4, 32'h4444_4444, 2'b11);
    rd_addr1 = 3'd4;
    mid();
    chk("t5_setwin", 32'(a_rd_busy1), 32'h1);
    tick();
    issue_addr = 3'd6;
    wr(3'd7, 32'h7777_7777, 2'b11);
    rd_addr1 = 3'd4; rd_addr2 = 3'd7;
    mid();
    chk("t5_r4b", 32'(a_rd_busy1), 32'h1);
    chk("t5_r4d", a_rd_data1, 32'h4444_4444);
    chk("t5_r7b", 32'(a_rd_busy2), 32'h0);
    chk("t5_r7n", 32'(n_rd_busy2), 32'h1);
    tick();
    issue_en = 1'b0; wr_en = 1'b0;
    rd_addr1 = 3'd6; rd_addr2 = 3'd7;
    mid();
    chk("t5_r6", 32'(a_rd_busy1), 32'h1);
    chk("t5_r7", 32'(a_rd_busy2), 32'h0);
    tick();

    // Mixed traffic, checked by the model
    for (int k = 0; k < 60; k++) begin
      rst        = ($urandom_range(0, 29) == 0);
      wr_en      = 1'($urandom);
      wr_addr    = 3'($urandom);
      wr_data    = 32'($urandom);
      wr_hmask   = 2'($urandom);
      issue_en   = 1'($urandom);
      issue_addr = 3'($urandom);
      rd_addr1   = 3'($urandom);
      rd_addr2   = (k % 4 == 0) ? rd_addr1 : 3'($urandom);
      if (k % 5 == 0) rd_addr1 = wr_addr;
      tick();
    end
    rst = 1'b0; wr_en = 1'b0; issue_en = 1'b0;
    tick();

    // 16-bit, 16-entry instance
    for (int a = 0; a < 16; a++) begin
      bwr(4'(a), 16'(16'h1357 * (a + 1)), 2'b11);
      tick();
    end
    b_wr_en = 1'b0;
    for (int a = 0; a < 16; a++) begin
      b_rd_addr1 = 4'(a);
      b_rd_addr2 = 4'(15 - a);
      mid();
      chk("t6_rd1", 32'(b_rd_data1), 32'(16'(16'h1357 * (a + 1))));
      chk("t6_rd2", 32'(b_rd_data2), 32'(16'(16'h1357 * (16 - a))));
      tick();
    end
    bwr(4'd15, 16'h00CD, 2'b11);
    tick();
    bwr(4'd15, 16'hAB00, 2'b10);
    tick();
    b_wr_en = 1'b0;
    b_rd_addr1 = 4'd15;
    mid();
    chk("t6_abcd", 32'(b_rd_data1), 32'h0000_ABCD);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
